lcd_cmd_sequencer: RTL and testbench
====================================

# lcd_cmd_sequencer

Command sequencer sitting between a host command source and the LCD_CTRL image-processing engine. Buffers host commands in a small FIFO, issues them one at a time on the engine's cmd/cmd_valid port under its busy handshake, tracks the final write-out until the engine's done, and flags a stalled engine with a watchdog. It sequences the engine; it does not touch IROM or IRAM.

## Interface
- DEPTH, 8: command FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 255: maximum consecutive cycles spent waiting on the engine before error.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; all state cleared on any edge where reset==0.
- cmd_in  in  4  host command, engine encoding: 0 write, 1-4 shift up/down/left/right, 5 max, 6 min, 7 avg, 8 ccw, 9 cw, 10 mirror X, 11 mirror Y, 12-15 finish.
- cmd_in_valid  in  1  host push request.
- cmd_in_ready  out  1  FIFO not full; push occurs when valid && ready.
- lcd_busy  in  1  engine busy.
- lcd_done  in  1  engine done.
- cmd  out  4  command to engine.
- cmd_valid  out  1  one-cycle issue strobe.
- seq_done  out  1  sticky, write-out complete.
- seq_err  out  1  sticky, watchdog expired.
- issued_cnt  out  16  commands issued, saturates at 16'hFFFF.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- cursor_x, cursor_y  out  3 each  shadow operation point (see Configuration).

## Operation
- States: BOOT, IDLE, ISSUE, WAIT, DRAIN, FINISH, ERROR. Reset enters BOOT.
- BOOT: wait for lcd_busy==0, which marks the end of the engine's image load. Then go to IDLE.
- IDLE: if the FIFO is non-empty, pop the head into the cmd register and go to ISSUE.
- ISSUE: cmd_valid=1 for exactly one cycle and issued_cnt increments.
  - Command 0 or 12-15 goes to DRAIN.
  - Any other command goes to WAIT.
- WAIT: cmd_valid=0. Return to IDLE on the first cycle with lcd_busy==0, checked at the earliest one cycle after ISSUE.
- DRAIN: wait for lcd_done==1, then go to FINISH.
- FINISH: seq_done=1. The FIFO keeps accepting pushes, but nothing is popped or issued.
- Watchdog: a counter runs in BOOT, WAIT and DRAIN and clears on every state change. When it reaches TIMEOUT_CYC the block goes to ERROR. ERROR sets seq_err=1, issues nothing and is left only by reset.
- cmd holds its last issued value; its value while cmd_valid==0 is don't-care.

## Timing
- All outputs are registered except cmd_in_ready (=!full) and fifo_level, which are combinational from the count.
- Reset values: cmd=0, cmd_valid=0, seq_done=0, seq_err=0, issued_cnt=0, fifo empty, fifo_level=0, cursor_x=cursor_y=4.
- Minimum issue spacing is 3 cycles (ISSUE, WAIT, IDLE).
- Latency from a push into an empty FIFO while in IDLE to cmd_valid is 2 cycles. There is no bypass.
- Push and pop in the same cycle leave the level unchanged. A push while full is ignored, since ready is 0.
- FIFO pointers wrap modulo DEPTH.
- lcd_done seen in any state other than DRAIN is ignored.
- Reset mid-operation empties the FIFO and returns to BOOT. The engine is reset separately and is not driven by this block.

## Configuration
- LCD_SEQ_CURSOR_TRACK_EN defined:
  - Shadow cursor x/y tracks shifts. Range is 1..7 for both, starting at 4,4: up is y-1, down is y+1, left is x-1, right is x+1.
  - A popped shift that would not move the cursor (saturated) is dropped in IDLE. Dropping costs one cycle, leaves issued_cnt unchanged and issues no cmd_valid.
- Undefined: every command is issued, and cursor_x and cursor_y are tied to 4.

## Structure
- Package lcd_seq_pkg holds:
  - command encoding constants (CMD_WRITE, CMD_SHIFT_UP ... CMD_MIRROR_Y);
  - the state enum;
  - the cursor bounds CUR_MIN=1, CUR_MAX=7 and CUR_INIT=4.
- Sub-module lcd_seq_fifo holds the DEPTH x 4 synchronous FIFO, with push/pop/full/empty/level and a synchronous active-low reset.

## Test plan
- Idle engine: after reset hold lcd_busy=1 for 70 cycles, then 0; push 5 (max) -> cmd_valid pulses with cmd=5 two cycles after the push; issued_cnt=1.
- Back-pressure: keep lcd_busy=1 after BOOT and push 9 commands with DEPTH=8 -> cmd_in_ready goes 0 after 8 pushes and the 9th is not accepted; release busy -> the 8 commands issue in order at 3-cycle spacing.
- Write-out: push 0 -> one cmd_valid with cmd=0, state DRAIN; lcd_done=1 after 66 cycles -> seq_done=1; a later push of 3 is never issued.
- Watchdog: issue 7 and hold lcd_busy=1 -> seq_err=1 exactly TIMEOUT_CYC cycles after entering WAIT; no further cmd_valid until reset.
- With LCD_SEQ_CURSOR_TRACK_EN: push up x4 -> 3 issued (y goes 4 to 1), the 4th dropped; issued_cnt=3, cursor_y=1.
- Mid-run reset: assert reset=0 for one cycle with 4 commands queued -> fifo_level=0, cmd_valid=0, back in BOOT.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD_CTRL command sequencer: command encoding, FSM states,
// cursor bounds and the shift/cursor helper functions.
package lcd_seq_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_WRITE       = 4'd0;
  localparam cmd_t CMD_SHIFT_UP    = 4'd1;
  localparam cmd_t CMD_SHIFT_DOWN  = 4'd2;
  localparam cmd_t CMD_SHIFT_LEFT  = 4'd3;
  localparam cmd_t CMD_SHIFT_RIGHT = 4'd4;
  localparam cmd_t CMD_MAX         = 4'd5;
  localparam cmd_t CMD_MIN         = 4'd6;
  localparam cmd_t CMD_AVG         = 4'd7;
  localparam cmd_t CMD_ROT_CCW     = 4'd8;
  localparam cmd_t CMD_ROT_CW      = 4'd9;
  localparam cmd_t CMD_MIRROR_X    = 4'd10;
  localparam cmd_t CMD_MIRROR_Y    = 4'd11;
  localparam cmd_t CMD_FINISH      = 4'd12;

  localparam logic [2:0] CUR_MIN  = 3'd1;
  localparam logic [2:0] CUR_MAX  = 3'd7;
  localparam logic [2:0] CUR_INIT = 3'd4;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERROR  = 3'd6
  } seq_state_t;

  function automatic logic is_shift(input cmd_t c);
    return (c >= CMD_SHIFT_UP) && (c <= CMD_SHIFT_RIGHT);
  endfunction

  // Write and every finish code hand the engine over to its write-out phase.
  function automatic logic ends_seq(input cmd_t c);
    return (c == CMD_WRITE) || (c >= CMD_FINISH);
  endfunction

  function automatic logic [5:0] cursor_next(input cmd_t c, input logic [2:0] x,
                                             input logic [2:0] y);
    logic [2:0] nx;
    logic [2:0] ny;
    nx = x;
    ny = y;
    case (c)
      CMD_SHIFT_UP:    ny = (y > CUR_MIN) ? (y - 3'd1) : y;
      CMD_SHIFT_DOWN:  ny = (y < CUR_MAX) ? (y + 3'd1) : y;
      CMD_SHIFT_LEFT:  nx = (x > CUR_MIN) ? (x - 3'd1) : x;
      CMD_SHIFT_RIGHT: nx = (x < CUR_MAX) ? (x + 3'd1) : x;
      default: ;
    endcase
    return {nx, ny};
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Host-side push handshake into the command sequencer.
interface lcd_cmd_sequencer_if;
  lcd_seq_pkg::cmd_t cmd_in;
  logic              cmd_in_valid;
  logic              cmd_in_ready;

  modport master (output cmd_in, output cmd_in_valid, input cmd_in_ready);
  modport slave  (input cmd_in, input cmd_in_valid, output cmd_in_ready);
endinterface

// File: rtl/lcd_seq_fifo.sv
// DEPTH x 4 synchronous command FIFO with head look-ahead, full/empty flags and occupancy.
module lcd_seq_fifo
  import lcd_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  assign full   = (count_r == (AW + 1)'(DEPTH));
  assign empty  = (count_r == '0);
  assign level  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage array; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to LCD_CTRL under its busy/done handshake.
// Define LCD_SEQ_CURSOR_TRACK_EN to shadow the operation point and drop saturated shifts.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  lcd_cmd_sequencer_if.slave     host,
  input  logic                   lcd_busy,
  input  logic                   lcd_done,
  output cmd_t                   cmd,
  output logic                   cmd_valid,
  output logic                   seq_done,
  output logic                   seq_err,
  output logic [15:0]            issued_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [2:0]             cursor_x,
  output logic [2:0]             cursor_y
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  seq_state_t      state_r;
  logic [WD_W-1:0] wd_r;
  cmd_t            cmd_r;
  logic            cmd_valid_r;
  logic            done_r;
  logic            err_r;
  logic [15:0]     cnt_r;
  logic [2:0]      cur_x_r;
  logic [2:0]      cur_y_r;

  cmd_t       head_s;
  logic       full_s;
  logic       empty_s;
  logic       pop_s;
  logic       drop_s;
  logic       wd_hit_s;
  logic [5:0] cur_nx_s;

  assign pop_s             = (state_r == ST_IDLE) && !empty_s;
  assign wd_hit_s          = (wd_r == WD_W'(TIMEOUT_CYC - 1));
  assign host.cmd_in_ready = !full_s;

  lcd_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host.cmd_in_valid),
    .din   (host.cmd_in),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

`ifdef LCD_SEQ_CURSOR_TRACK_EN
  assign cur_nx_s = cursor_next(head_s, cur_x_r, cur_y_r);
  assign drop_s   = is_shift(head_s) && (cur_nx_s == {cur_x_r, cur_y_r});
`else
  assign cur_nx_s = {CUR_INIT, CUR_INIT};
  assign drop_s   = 1'b0;
`endif

  // Sequencer FSM; the watchdog restarts from zero on every state change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_BOOT;
      wd_r        <= '0;
      cmd_r       <= CMD_WRITE;
      cmd_valid_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= 16'd0;
      cur_x_r     <= CUR_INIT;
      cur_y_r     <= CUR_INIT;
    end else begin
      cmd_valid_r <= 1'b0;
      wd_r        <= '0;
      case (state_r)
        ST_BOOT: begin
          if (!lcd_busy) begin
            state_r <= ST_IDLE;
          end else if (wd_hit_s) begin
            state_r <= ST_ERROR;
            err_r   <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        // A dropped shift is popped but leaves the FSM in IDLE for another look.
        ST_IDLE: begin
          if (!empty_s && !drop_s) begin
            cmd_r       <= head_s;
            cmd_valid_r <= 1'b1;
            cur_x_r     <= cur_nx_s[5:3];
            cur_y_r     <= cur_nx_s[2:0];
            state_r     <= ST_ISSUE;
            if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_ISSUE: state_r <= ends_seq(cmd_r) ? ST_DRAIN : ST_WAIT;
        ST_WAIT: begin
          if (!lcd_busy) begin
            state_r <= ST_IDLE;
          end else if (wd_hit_s) begin
            state_r <= ST_ERROR;
            err_r   <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        ST_DRAIN: begin
          if (lcd_done) begin
            state_r <= ST_FINISH;
            done_r  <= 1'b1;
          end else if (wd_hit_s) begin
            state_r <= ST_ERROR;
            err_r   <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        ST_FINISH: state_r <= ST_FINISH;
        ST_ERROR:  state_r <= ST_ERROR;
        default: begin
          state_r <= ST_ERROR;
          err_r   <= 1'b1;
        end
      endcase
    end
  end

  assign cmd        = cmd_r;
  assign cmd_valid  = cmd_valid_r;
  assign seq_done   = done_r;
  assign seq_err    = err_r;
  assign issued_cnt = cnt_r;
  assign cursor_x   = cur_x_r;
  assign cursor_y   = cur_y_r;
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: vector table plus scoreboard of issued commands.
module tb_lcd_cmd_sequencer;
  localparam int DEPTH       = 8;
  localparam int TIMEOUT_CYC = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        lcd_busy;
  logic        lcd_done;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        seq_done;
  logic        seq_err;
  logic [15:0] issued_cnt;
  logic [3:0]  fifo_level;
  logic [2:0]  cursor_x;
  logic [2:0]  cursor_y;

  lcd_cmd_sequencer_if host ();

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (host),
    .lcd_busy   (lcd_busy),
    .lcd_done   (lcd_done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .seq_done   (seq_done),
    .seq_err    (seq_err),
    .issued_cnt (issued_cnt),
    .fifo_level (fifo_level),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    int          busy_hold;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] bp [9];
  logic [3:0] sb [$];
  int         issue_cyc [$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         lat;
  int         k;
  logic [3:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] c, input bit expect_issue);
    host.cmd_in       = c;
    host.cmd_in_valid = 1'b1;
    if (expect_issue) sb.push_back(c);
    tick();
    host.cmd_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_issue();
    lat = 1;
    while (cmd_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("issue_latency", lat, 2);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every issue strobe must match the oldest expected command.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      issue_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got cmd %0d, expected no issue", cmd);
      end else begin
        mon_exp = sb.pop_front();
        check("issued_cmd", int'(cmd), int'(mon_exp));
      end
    end
  end

  initial begin
    vecs[0] = '{4'd5,  0, 16'd1};
    vecs[1] = '{4'd1,  3, 16'd2};
    vecs[2] = '{4'd8,  0, 16'd3};
    vecs[3] = '{4'd11, 5, 16'd4};
    vecs[4] = '{4'd4,  1, 16'd5};
    vecs[5] = '{4'd7,  2, 16'd6};
    bp = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

    reset             = 1'b0;
    lcd_busy          = 1'b1;
    lcd_done          = 1'b0;
    host.cmd_in       = 4'd0;
    host.cmd_in_valid = 1'b0;
    tick();
    tick();
    check("rst_cmd", int'(cmd), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_seq_done", int'(seq_done), 0);
    check("rst_seq_err", int'(seq_err), 0);
    check("rst_issued_cnt", int'(issued_cnt), 0);
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_cursor_x", int'(cursor_x), 4);
    check("rst_cursor_y", int'(cursor_y), 4);
    check("rst_ready", int'(host.cmd_in_ready), 1);
    reset = 1'b1;

    // Engine image load, then idle.
    for (int i = 0; i < 70; i++) tick();
    lcd_busy = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 6; i++) begin
      push_cmd(vecs[i].c, 1'b1);
      wait_issue();
      check("issued_cnt", int'(issued_cnt), int'(vecs[i].exp_cnt));
      lcd_busy = (vecs[i].busy_hold > 0);
      for (int j = 0; j < vecs[i].busy_hold; j++) tick();
      lcd_busy = 1'b0;
      tick();
      tick();
      tick();
    end
    check("fifo_level_drained", int'(fifo_level), 0);
    check("cmd_holds_last", int'(cmd), 7);
`ifdef LCD_SEQ_CURSOR_TRACK_EN
    check("cursor_x_tbl", int'(cursor_x), 5);
    check("cursor_y_tbl", int'(cursor_y), 3);
`else
    check("cursor_x_tbl", int'(cursor_x), 4);
    check("cursor_y_tbl", int'(cursor_y), 4);
`endif

    // lcd_done outside DRAIN must be ignored.
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    tick();
    check("done_ignored", int'(seq_done), 0);

    // Mid-run reset with four commands queued in BOOT.
    check("sb_empty_pre_reset", sb.size(), 0);
    lcd_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd(bp[i], 1'b0);
    check("level_queued", int'(fifo_level), 4);
    do_reset();
    check("mid_rst_level", int'(fifo_level), 0);
    check("mid_rst_cmd_valid", int'(cmd_valid), 0);
    check("mid_rst_cnt", int'(issued_cnt), 0);
    for (int i = 0; i < 10; i++) tick();

    // Back-pressure: still in BOOT, fill the FIFO and try one more.
    for (int i = 0; i < 9; i++) begin
      check("ready_before_push", int'(host.cmd_in_ready), (i < 8) ? 1 : 0);
      push_cmd(bp[i], i < 8);
    end
    check("bp_level_full", int'(fifo_level), 8);
    check("bp_ready_low", int'(host.cmd_in_ready), 0);
    issue_cyc.delete();
    lcd_busy = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("bp_issue_count", issue_cyc.size(), 8);
    for (int j = 1; j < issue_cyc.size(); j++)
      check("bp_issue_spacing", issue_cyc[j] - issue_cyc[j-1], 3);
    check("bp_issued_cnt", int'(issued_cnt), 8);
    check("bp_sb_empty", sb.size(), 0);

    // Write-out: DRAIN until lcd_done, then FINISH ignores new commands.
    push_cmd(4'd0, 1'b1);
    wait_issue();
    tick();
    for (int i = 0; i < 66; i++) tick();
    check("drain_not_done", int'(seq_done), 0);
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    check("seq_done_set", int'(seq_done), 1);
    push_cmd(4'd3, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("finish_level", int'(fifo_level), 1);
    check("finish_done_sticky", int'(seq_done), 1);
    check("finish_cnt", int'(issued_cnt), 9);

    // Watchdog: engine stays busy after an issue.
    lcd_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    lcd_busy = 1'b0;
    tick();
    tick();
    push_cmd(4'd7, 1'b1);
    wait_issue();
    lcd_busy = 1'b1;
    tick();
    k = 0;
    while (seq_err !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check("wd_cycles", k, TIMEOUT_CYC);
    push_cmd(4'd5, 1'b0);
    lcd_busy = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("err_sticky", int'(seq_err), 1);
    check("err_cnt", int'(issued_cnt), 1);
    check("err_level", int'(fifo_level), 1);

    // Shift-up saturation.
    lcd_busy = 1'b1;
    do_reset();
    lcd_busy = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
`ifdef LCD_SEQ_CURSOR_TRACK_EN
      push_cmd(4'd1, i < 3);
`else
      push_cmd(4'd1, 1'b1);
`endif
    end
    for (int i = 0; i < 30; i++) tick();
`ifdef LCD_SEQ_CURSOR_TRACK_EN
    check("cur_cnt", int'(issued_cnt), 3);
    check("cur_y", int'(cursor_y), 1);
`else
    check("cur_cnt", int'(issued_cnt), 4);
    check("cur_y", int'(cursor_y), 4);
`endif
    check("cur_x", int'(cursor_x), 4);
    check("cur_level", int'(fifo_level), 0);
    check("cur_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
